// File: rtl/add_sub_reservation_station.sv
// add_sub_reservation_station: operand-gathering issue queue for one add/sub unit, snooping a single CDB.
package add_sub_rs_pkg;
  typedef struct packed {
    logic sub;
    logic use_ca;
    logic set_ca;
    logic set_ov;
    logic set_cr0;
  } add_sub_decode_t;
endpackage

module add_sub_reservation_station
  import add_sub_rs_pkg::*;
#(
  parameter int RS_ENTRIES  = 4,
  parameter int RS_ID_WIDTH = 5,
  parameter int RS_OFFSET   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dispatch_valid,
  output logic                   dispatch_ready,
  input  logic                   op1_valid,
  input  logic                   op2_valid,
  input  logic                   xer_valid_in,
  input  logic [31:0]            op1_value,
  input  logic [31:0]            op2_value,
  input  logic [31:0]            xer_value,
  input  logic [RS_ID_WIDTH-1:0] op1_tag,
  input  logic [RS_ID_WIDTH-1:0] op2_tag,
  input  logic [RS_ID_WIDTH-1:0] xer_tag,
  input  add_sub_decode_t        control_in,
  input  logic [4:0]             result_reg_addr_in,
  input  logic                   cdb_valid,
  input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
  input  logic [31:0]            cdb_result,
  input  logic                   cdb_xer_valid,
  input  logic [31:0]            cdb_xer,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [RS_ID_WIDTH-1:0] rs_id_out,
  output logic [4:0]             result_reg_addr_out,
  output logic [31:0]            op1,
  output logic [31:0]            op2,
  output logic [31:0]            xer_out,
  output add_sub_decode_t        control_out
);
  localparam int IW = $clog2(RS_ENTRIES);
  typedef struct packed {
    logic                   rdy;
    logic [31:0]            val;
    logic [RS_ID_WIDTH-1:0] tag;
  } opnd_t;
  logic [RS_ENTRIES-1:0] busy, elig;
  opnd_t a [RS_ENTRIES];
  opnd_t b [RS_ENTRIES];
  opnd_t x [RS_ENTRIES];
  add_sub_decode_t ctl [RS_ENTRIES];
  logic [4:0] rd [RS_ENTRIES];
  logic lock, any_elig, disp, fire;
  logic [IW-1:0] lock_idx, free_idx, pick_idx, sel;

  function automatic opnd_t snoop(input opnd_t o, input logic hit, input logic [RS_ID_WIDTH-1:0] id,
                                  input logic [31:0] bus);
    return (!o.rdy && hit && o.tag == id) ? '{1'b1, bus, o.tag} : o;
  endfunction

  for (genvar g = 0; g < RS_ENTRIES; g++) begin : g_elig
    assign elig[g] = busy[g] & a[g].rdy & b[g].rdy & x[g].rdy;
  end

  always_comb begin
    free_idx = '0;
    pick_idx = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      free_idx = busy[i] ? free_idx : IW'(i);
      pick_idx = elig[i] ? IW'(i) : pick_idx;
    end
  end

  assign any_elig       = |elig;
  assign sel            = lock ? lock_idx : pick_idx;
  assign issue_valid    = lock | any_elig;
  assign dispatch_ready = !rst && !(&busy);
  assign disp           = dispatch_valid & dispatch_ready;
  assign fire           = issue_valid & issue_ready;

  assign rs_id_out           = issue_valid ? RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(sel) : '0;
  assign op1                 = issue_valid ? a[sel].val : '0;
  assign op2                 = issue_valid ? b[sel].val : '0;
  assign xer_out             = issue_valid ? x[sel].val : '0;
  assign control_out         = issue_valid ? ctl[sel] : '0;
  assign result_reg_addr_out = issue_valid ? rd[sel] : '0;

  // dispatch only targets a free entry, so it never collides with snoop or issue of the same slot
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        a[i]   <= '0;
        b[i]   <= '0;
        x[i]   <= '0;
        ctl[i] <= '0;
        rd[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
        if (busy[i]) begin
          a[i] <= snoop(a[i], cdb_valid, cdb_rs_id, cdb_result);
          b[i] <= snoop(b[i], cdb_valid, cdb_rs_id, cdb_result);
          x[i] <= snoop(x[i], cdb_valid & cdb_xer_valid, cdb_rs_id, cdb_xer);
        end
        if (disp && free_idx == IW'(i)) begin
          busy[i] <= 1'b1;
          a[i]    <= snoop('{op1_valid, op1_value, op1_tag}, cdb_valid, cdb_rs_id, cdb_result);
          b[i]    <= snoop('{op2_valid, op2_value, op2_tag}, cdb_valid, cdb_rs_id, cdb_result);
          x[i]    <= snoop('{xer_valid_in, xer_value, xer_tag}, cdb_valid & cdb_xer_valid, cdb_rs_id, cdb_xer);
          ctl[i]  <= control_in;
          rd[i]   <= result_reg_addr_in;
        end
        if (fire && sel == IW'(i)) busy[i] <= 1'b0;
      end
      lock <= issue_valid & ~issue_ready;
      if (issue_valid & ~issue_ready) lock_idx <= sel;
    end
  end
endmodule

// File: tb/tb_add_sub_reservation_station.sv
// tb_add_sub_reservation_station: directed scenario tests for the add/sub reservation station.
module tb_add_sub_reservation_station;
  import add_sub_rs_pkg::*;
  logic clk = 0, rst = 1;
  logic dispatch_valid = 0, dispatch_ready;
  logic op1_valid = 0, op2_valid = 0, xer_valid_in = 0;
  logic [31:0] op1_value = 0, op2_value = 0, xer_value = 0;
  logic [4:0] op1_tag = 0, op2_tag = 0, xer_tag = 0;
  add_sub_decode_t control_in = '0, control_out;
  logic [4:0] result_reg_addr_in = 0, result_reg_addr_out;
  logic cdb_valid = 0, cdb_xer_valid = 0;
  logic [4:0] cdb_rs_id = 0;
  logic [31:0] cdb_result = 0, cdb_xer = 0;
  logic issue_valid, issue_ready = 0;
  logic [4:0] rs_id_out;
  logic [31:0] op1, op2, xer_out;
  int checks = 0, errors = 0;

  add_sub_reservation_station #(.RS_ENTRIES(4), .RS_ID_WIDTH(5), .RS_OFFSET(0)) dut (
    .clk(clk), .rst(rst), .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .op1_valid(op1_valid), .op2_valid(op2_valid), .xer_valid_in(xer_valid_in),
    .op1_value(op1_value), .op2_value(op2_value), .xer_value(xer_value),
    .op1_tag(op1_tag), .op2_tag(op2_tag), .xer_tag(xer_tag),
    .control_in(control_in), .result_reg_addr_in(result_reg_addr_in),
    .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_result(cdb_result),
    .cdb_xer_valid(cdb_xer_valid), .cdb_xer(cdb_xer),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .rs_id_out(rs_id_out),
    .result_reg_addr_out(result_reg_addr_out), .op1(op1), .op2(op2), .xer_out(xer_out),
    .control_out(control_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic v1, input logic [31:0] d1, input logic [4:0] t1,
                      input logic v2, input logic [31:0] d2, input logic [4:0] t2,
                      input logic vx, input logic [31:0] dx, input logic [4:0] tx);
    dispatch_valid = 1;
    op1_valid = v1; op1_value = d1; op1_tag = t1;
    op2_valid = v2; op2_value = d2; op2_tag = t2;
    xer_valid_in = vx; xer_value = dx; xer_tag = tx;
  endtask

  task automatic cdb(input logic [4:0] id, input logic [31:0] r, input logic xv, input logic [31:0] xr);
    cdb_valid = 1; cdb_rs_id = id; cdb_result = r; cdb_xer_valid = xv; cdb_xer = xr;
  endtask

  task automatic idle();
    dispatch_valid = 0;
    cdb_valid = 0;
    cdb_xer_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    step();
    checks++; if (dispatch_ready !== 1'b0) begin errors++; $display("FAIL reset_dready got %b exp 0", dispatch_ready); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_ivalid got %b exp 0", issue_valid); end
    rst = 0;
    step();
    checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL reset_dready_after got %b exp 1", dispatch_ready); end
    checks++; if (issue_valid !== 1'b0 || op1 !== 0 || op2 !== 0 || xer_out !== 0 || rs_id_out !== 0)
      begin errors++; $display("FAIL reset_outputs got v=%b op1=%h op2=%h xer=%h id=%0d exp all 0", issue_valid, op1, op2, xer_out, rs_id_out); end
  endtask

  task automatic test_basic();
    control_in = '{sub: 1'b1, use_ca: 1'b0, set_ca: 1'b1, set_ov: 1'b0, set_cr0: 1'b1};
    result_reg_addr_in = 5'd17;
    disp(1, 5, 0, 1, 7, 0, 1, 0, 0);
    step();
    idle();
    checks++; if (issue_valid !== 1'b1 || rs_id_out !== 5'd0) begin errors++; $display("FAIL basic_issue got v=%b id=%0d exp v=1 id=0", issue_valid, rs_id_out); end
    checks++; if (op1 !== 32'd5 || op2 !== 32'd7 || xer_out !== 32'd0) begin errors++; $display("FAIL basic_ops got %0d %0d %0d exp 5 7 0", op1, op2, xer_out); end
    checks++; if (control_out !== 5'b10101 || result_reg_addr_out !== 5'd17) begin errors++; $display("FAIL basic_ctl got %b rd=%0d exp 10101 rd=17", control_out, result_reg_addr_out); end
    issue_ready = 1;
    step();
    issue_ready = 0;
    checks++; if (issue_valid !== 1'b0 || dispatch_ready !== 1'b1) begin errors++; $display("FAIL basic_free got v=%b dr=%b exp v=0 dr=1", issue_valid, dispatch_ready); end
  endtask

  task automatic test_cdb_capture();
    disp(1, 1, 0, 0, 0, 3, 0, 0, 3);
    step();
    idle();
    step();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL cdb_pending got %b exp 0", issue_valid); end
    cdb(3, 32'h10, 0, 32'hdead);
    step();
    idle();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL cdb_xer_untouched got %b exp 0", issue_valid); end
    cdb(3, 32'h99, 1, 32'h2000_0000);
    step();
    idle();
    checks++; if (issue_valid !== 1'b1 || op2 !== 32'h10 || xer_out !== 32'h2000_0000)
      begin errors++; $display("FAIL cdb_capture got v=%b op2=%h xer=%h exp v=1 op2=10 xer=20000000", issue_valid, op2, xer_out); end
    issue_ready = 1;
    step();
    issue_ready = 0;
  endtask

  task automatic test_bypass();
    disp(0, 0, 7, 1, 2, 0, 1, 0, 0);
    cdb(7, 32'h55, 0, 0);
    step();
    idle();
    checks++; if (issue_valid !== 1'b1 || op1 !== 32'h55 || op2 !== 32'd2)
      begin errors++; $display("FAIL bypass got v=%b op1=%h op2=%h exp v=1 op1=55 op2=2", issue_valid, op1, op2); end
    issue_ready = 1;
    step();
    issue_ready = 0;
  endtask

  task automatic test_full_lock();
    for (int i = 0; i < 4; i++) begin
      disp(0, 0, 5'(10 + i), 1, i, 0, 1, 0, 0);
      step();
    end
    checks++; if (dispatch_ready !== 1'b0 || issue_valid !== 1'b0) begin errors++; $display("FAIL full got dr=%b v=%b exp dr=0 v=0", dispatch_ready, issue_valid); end
    disp(1, 1, 0, 1, 1, 0, 1, 0, 0);
    step();
    idle();
    checks++; if (issue_valid !== 1'b0 || dispatch_ready !== 1'b0) begin errors++; $display("FAIL full_ignore got v=%b dr=%b exp v=0 dr=0", issue_valid, dispatch_ready); end
    cdb(12, 32'h1200, 0, 0);
    step();
    idle();
    checks++; if (issue_valid !== 1'b1 || rs_id_out !== 5'd2 || op1 !== 32'h1200)
      begin errors++; $display("FAIL lock_first got v=%b id=%0d op1=%h exp v=1 id=2 op1=1200", issue_valid, rs_id_out, op1); end
    cdb(10, 32'h1000, 0, 0);
    step();
    idle();
    checks++; if (rs_id_out !== 5'd2) begin errors++; $display("FAIL lock_hold1 got id=%0d exp 2", rs_id_out); end
    step();
    checks++; if (rs_id_out !== 5'd2 || op1 !== 32'h1200) begin errors++; $display("FAIL lock_hold2 got id=%0d op1=%h exp id=2 op1=1200", rs_id_out, op1); end
    issue_ready = 1;
    step();
    checks++; if (issue_valid !== 1'b1 || rs_id_out !== 5'd0 || op1 !== 32'h1000 || dispatch_ready !== 1'b1)
      begin errors++; $display("FAIL lock_next got v=%b id=%0d op1=%h dr=%b exp v=1 id=0 op1=1000 dr=1", issue_valid, rs_id_out, op1, dispatch_ready); end
    step();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL lock_drain got %b exp 0", issue_valid); end
    cdb(11, 32'h1100, 0, 0);
    step();
    idle();
    checks++; if (rs_id_out !== 5'd1 || op1 !== 32'h1100) begin errors++; $display("FAIL drain_e1 got id=%0d op1=%h exp id=1 op1=1100", rs_id_out, op1); end
    cdb(13, 32'h1300, 0, 0);
    step();
    idle();
    checks++; if (rs_id_out !== 5'd3 || op1 !== 32'h1300) begin errors++; $display("FAIL drain_e3 got id=%0d op1=%h exp id=3 op1=1300", rs_id_out, op1); end
    step();
    issue_ready = 0;
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", issue_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      disp(1, 100 + i, 0, 1, 0, 0, 1, 0, 0);
      step();
    end
    idle();
    checks++; if (rs_id_out !== 5'd0 || op1 !== 32'd100) begin errors++; $display("FAIL b2b_0 got id=%0d op1=%0d exp id=0 op1=100", rs_id_out, op1); end
    issue_ready = 1;
    step();
    checks++; if (rs_id_out !== 5'd1 || op1 !== 32'd101) begin errors++; $display("FAIL b2b_1 got id=%0d op1=%0d exp id=1 op1=101", rs_id_out, op1); end
    checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL b2b_dready got %b exp 1", dispatch_ready); end
    disp(0, 0, 20, 1, 0, 0, 1, 0, 0);
    step();
    idle();
    checks++; if (rs_id_out !== 5'd2 || op1 !== 32'd102) begin errors++; $display("FAIL b2b_2 got id=%0d op1=%0d exp id=2 op1=102", rs_id_out, op1); end
    step();
    checks++; if (rs_id_out !== 5'd3 || op1 !== 32'd103) begin errors++; $display("FAIL b2b_3 got id=%0d op1=%0d exp id=3 op1=103", rs_id_out, op1); end
    step();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL b2b_done got %b exp 0", issue_valid); end
    issue_ready = 0;
    cdb(20, 32'h77, 0, 0);
    step();
    idle();
    checks++; if (issue_valid !== 1'b1 || rs_id_out !== 5'd0 || op1 !== 32'h77)
      begin errors++; $display("FAIL b2b_landed got v=%b id=%0d op1=%h exp v=1 id=0 op1=77", issue_valid, rs_id_out, op1); end
    step();
  endtask

  task automatic test_rst_mid();
    rst = 1;
    #1;
    checks++; if (dispatch_ready !== 1'b0) begin errors++; $display("FAIL rstmid_dready got %b exp 0", dispatch_ready); end
    step();
    checks++; if (issue_valid !== 1'b0 || op1 !== 0 || rs_id_out !== 0)
      begin errors++; $display("FAIL rstmid_withdraw got v=%b op1=%h id=%0d exp all 0", issue_valid, op1, rs_id_out); end
    rst = 0;
    step();
    checks++; if (dispatch_ready !== 1'b1 || issue_valid !== 1'b0) begin errors++; $display("FAIL rstmid_free got dr=%b v=%b exp dr=1 v=0", dispatch_ready, issue_valid); end
    disp(1, 9, 0, 1, 0, 0, 1, 0, 0);
    step();
    idle();
    checks++; if (rs_id_out !== 5'd0 || op1 !== 32'd9) begin errors++; $display("FAIL rstmid_realloc got id=%0d op1=%0d exp id=0 op1=9", rs_id_out, op1); end
    issue_ready = 1;
    step();
    issue_ready = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cdb_capture();
    test_bypass();
    test_full_lock();
    test_back_to_back();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
